gshare_pht: RTL
===============

# gshare_pht

Gshare pattern history table that consumes the global history produced by the branch history register. Fetch 1 supplies a PC and the speculative history. The block XORs them into a table index and returns a registered taken/not-taken prediction. Retired branches supply PC, update-history and outcome, and the block trains the indexed 2-bit saturating counter through a two-stage read-modify-write pipeline. After reset, an init sweep clears the table before the block accepts any traffic.

## Interface
- SIZE_CNT_TBL_LOG, 16, table index width; equals history width; table holds 2^SIZE_CNT_TBL_LOG counters
- PC_LSB, 2, lowest PC bit used for indexing
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall_i  in  1  fetch stall; holds prediction output register
- recoverFlag_i  in  1  pipeline recovery; kills the in-flight prediction
- pred_req_i  in  1  Fetch 1 prediction request
- pred_pc_i  in  32  fetch PC
- pred_bhr_i  in  SIZE_CNT_TBL_LOG  speculative history (bhr_o)
- pred_valid_o  out  1  prediction valid
- pred_dir_o  out  1  1 = taken
- pred_idx_o  out  SIZE_CNT_TBL_LOG  index used; carried to the control queue
- upd_valid_i  in  1  retired-branch update
- upd_pc_i  in  32  retired branch PC
- upd_bhr_i  in  SIZE_CNT_TBL_LOG  update history (bhr_upd_o)
- upd_dir_i  in  1  actual outcome
- ready_o  out  1  init sweep complete

## Operation
- Index = pred_pc_i[PC_LSB+SIZE_CNT_TBL_LOG-1:PC_LSB] ^ history. Prediction and update paths use the same function.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction is the counter MSB.
- Training: taken increments the counter, saturating at 11. Not-taken decrements it, saturating at 00.
- The FSM has two states, INIT and READY.
  - Reset forces INIT with sweep pointer 0.
  - INIT writes 01 to entry[pointer] each cycle and increments the pointer.
  - When the pointer reaches 2^N-1 and that entry is written, the FSM moves to READY.
  - READY is terminal until the next reset.
- In INIT:
  - ready_o = 0 and pred_valid_o = 0.
  - pred_req_i and upd_valid_i are ignored (dropped, not queued).
- In READY, prediction:
  - The table is read combinationally at the request index.
  - Result is registered into pred_dir_o/pred_idx_o with pred_valid_o = pred_req_i.
- In READY, update pipeline:
  - U1 registers index and dir, and reads the counter.
  - U2 computes the saturated value and writes it.
  - One update is accepted per cycle with no backpressure.
- Hazards:
  - Write-first: a prediction read whose index equals the U2 write index returns the new value.
  - U1 forwarding: if the U1 index equals the U2 index in the same cycle, U1 uses the U2 result, not the stale array value. Back-to-back updates to one entry therefore accumulate.
- Reset mid-operation restarts the sweep from 0. In-flight U1/U2 contents are discarded and no write is issued.

## Timing
- Reset values:
  - pred_valid_o = 0, pred_dir_o = 0, pred_idx_o = 0, ready_o = 0.
  - U1/U2 valid = 0, sweep pointer = 0.
- Init lasts exactly 2^SIZE_CNT_TBL_LOG cycles after reset deasserts. ready_o rises on the following edge.
- Prediction latency is 1 cycle: request in cycle t, output valid in t+1.
- stall_i = 1 and recoverFlag_i = 0: the output register holds and the new request is dropped.
- recoverFlag_i = 1: pred_valid_o becomes 0 on the next edge, regardless of stall_i or pred_req_i.
- An update accepted in cycle t reads in t+1 (U1) and writes on the edge ending t+2 (U2). A prediction issued in t+2 to the same index sees the new value through bypass.
- The update path ignores stall_i and recoverFlag_i.

## Structure
- Shared package holds:
  - SIZE_CNT_TBL_LOG
  - counter encodings (SNT/WNT/WT/ST)
  - counter init value (WNT)
  - FSM state encoding (INIT/READY)
  - the index hash function
- Sub-module pht_ram_2r1w: 2^N x 2-bit array with two asynchronous read ports (predict, U1) and one synchronous write port. Bypass and forwarding live in the parent.
- Write-port mux: the sweep writer in INIT, the U2 writer in READY.

## Test plan
All scenarios use SIZE_CNT_TBL_LOG = 6.
- Reset, then idle → ready_o low for 64 cycles, high on cycle 65. Every index then predicts not-taken (counter 01).
- During INIT, pred_req_i = 1 and upd_valid_i = 1 (pc=0x40, dir=1) → pred_valid_o stays 0. After ready, index 0x10 still predicts NT.
- pc=0x100, bhr=0x05 (idx 0x00^0x05 = 0x05), two taken updates on consecutive cycles → counter 11. Predict at idx 0x05 → taken. Four NT updates → counter 00, no wrap below 0.
- Update to idx 0x05 taken, then predict idx 0x05 in the write cycle of a 01→10 update → pred_dir_o = 1 (bypass).
- Predict request with stall_i = 1 → output unchanged. Predict, then recoverFlag_i in the next cycle → pred_valid_o = 0.
- Assert reset mid-update (U2 valid, entry at 10) → no write lands. The sweep restarts, and after 64 cycles the entry reads 01.

Source files
------------

// File: rtl/gshare_pht_pkg.sv
// Shared definitions for the gshare pattern history table: counter encodings,
// FSM states and the PC/history index hash.
package gshare_pht_pkg;

    localparam int unsigned SIZE_CNT_TBL_LOG = 16;

    localparam logic [1:0] CNT_SNT  = 2'b00;
    localparam logic [1:0] CNT_WNT  = 2'b01;
    localparam logic [1:0] CNT_WT   = 2'b10;
    localparam logic [1:0] CNT_ST   = 2'b11;
    localparam logic [1:0] CNT_INIT = CNT_WNT;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Full-width hash; callers size-cast the result to the table index width.
    function automatic logic [31:0] pht_hash(input logic [31:0] pc,
                                             input logic [31:0] hist,
                                             input int unsigned pc_lsb);
        return (pc >> pc_lsb) ^ hist;
    endfunction

    function automatic logic [1:0] cnt_train(input logic [1:0] cnt,
                                             input logic       taken);
        if (taken)
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        else
            return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/gshare_pht_ram_2r1w.sv
// 2^IDX_W x 2-bit counter array: two asynchronous read ports, one synchronous
// write port. Hazard handling is done by the parent.
module pht_ram_2r1w #(
    parameter int unsigned IDX_W = 16
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [1:0]       i_wdata,
    input  logic [IDX_W-1:0] i_raddr_a,
    output logic [1:0]       o_rdata_a,
    input  logic [IDX_W-1:0] i_raddr_b,
    output logic [1:0]       o_rdata_b
);

    logic [1:0] r_mem [0:(1<<IDX_W)-1];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/gshare_pht.sv
// Gshare PHT: registered prediction from PC^history, two-stage counter training
// pipeline, and a post-reset sweep that initialises every counter to weak NT.
module gshare_pht #(
    parameter int unsigned SIZE_CNT_TBL_LOG = gshare_pht_pkg::SIZE_CNT_TBL_LOG,
    parameter int unsigned PC_LSB           = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall_i,
    input  logic                        recoverFlag_i,
    input  logic                        pred_req_i,
    input  logic [31:0]                 pred_pc_i,
    input  logic [SIZE_CNT_TBL_LOG-1:0] pred_bhr_i,
    output logic                        pred_valid_o,
    output logic                        pred_dir_o,
    output logic [SIZE_CNT_TBL_LOG-1:0] pred_idx_o,
    input  logic                        upd_valid_i,
    input  logic [31:0]                 upd_pc_i,
    input  logic [SIZE_CNT_TBL_LOG-1:0] upd_bhr_i,
    input  logic                        upd_dir_i,
    output logic                        ready_o
);

    import gshare_pht_pkg::*;

    localparam int unsigned N = SIZE_CNT_TBL_LOG;

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_ptr, w_ptr_nxt;

    logic           w_we;
    logic [N-1:0]   w_waddr;
    logic [1:0]     w_wdata;

    logic [N-1:0]   w_pred_idx, w_upd_idx;
    logic [1:0]     w_pred_ram, w_pred_cnt;

    logic           r_u1_valid, r_u1_dir;
    logic [N-1:0]   r_u1_idx;
    logic [1:0]     w_u1_ram, w_u1_cnt;

    logic           r_u2_valid, r_u2_dir;
    logic [N-1:0]   r_u2_idx;
    logic [1:0]     r_u2_cnt, w_u2_new;

    assign w_pred_idx = N'(pht_hash(pred_pc_i, 32'(pred_bhr_i), PC_LSB));
    assign w_upd_idx  = N'(pht_hash(upd_pc_i,  32'(upd_bhr_i),  PC_LSB));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Writes are suppressed on a reset edge so an in-flight U2 never lands.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_we        = 1'b0;
        w_waddr     = r_u2_idx;
        w_wdata     = w_u2_new;
        case (r_state)
            INIT: begin
                w_we      = ~reset;
                w_waddr   = r_ptr;
                w_wdata   = CNT_INIT;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == '1)
                    w_state_nxt = READY;
            end
            READY: begin
                w_we = r_u2_valid & ~reset;
            end
            default: w_state_nxt = INIT;
        endcase
    end

    assign ready_o = (r_state == READY);

    pht_ram_2r1w #(.IDX_W(N)) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_pred_idx),
        .o_rdata_a (w_pred_ram),
        .i_raddr_b (r_u1_idx),
        .o_rdata_b (w_u1_ram)
    );

    assign w_u2_new   = cnt_train(r_u2_cnt, r_u2_dir);
    assign w_pred_cnt = (r_u2_valid && (r_u2_idx == w_pred_idx)) ? w_u2_new : w_pred_ram;
    assign w_u1_cnt   = (r_u2_valid && (r_u2_idx == r_u1_idx))   ? w_u2_new : w_u1_ram;

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_o <= 1'b0;
            pred_dir_o   <= 1'b0;
            pred_idx_o   <= '0;
        end else if (r_state != READY || recoverFlag_i) begin
            pred_valid_o <= 1'b0;
        end else if (!stall_i) begin
            pred_valid_o <= pred_req_i;
            pred_dir_o   <= w_pred_cnt[1];
            pred_idx_o   <= w_pred_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_u1_valid <= 1'b0;
            r_u1_dir   <= 1'b0;
            r_u1_idx   <= '0;
            r_u2_valid <= 1'b0;
            r_u2_dir   <= 1'b0;
            r_u2_idx   <= '0;
            r_u2_cnt   <= CNT_INIT;
        end else begin
            r_u1_valid <= upd_valid_i && (r_state == READY);
            r_u1_dir   <= upd_dir_i;
            r_u1_idx   <= w_upd_idx;
            r_u2_valid <= r_u1_valid;
            r_u2_dir   <= r_u1_dir;
            r_u2_idx   <= r_u1_idx;
            r_u2_cnt   <= w_u1_cnt;
        end
    end

endmodule
